// File: rtl/param_shift_reg.sv
// rtl/param_shift_reg.sv - WIDTH-bit universal shift register with word-completion counter.
// Optional: PARAM_SHIFT_REG_ROTATE_EN turns both shift modes into rotates (serial inputs ignored).
module param_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [1:0]       MODE_HOLD  = 2'b00;
  localparam logic [1:0]       MODE_RIGHT = 2'b01;
  localparam logic [1:0]       MODE_LEFT  = 2'b10;
  localparam logic [1:0]       MODE_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done_next;
  logic             w_in_r;
  logic             w_in_l;
  logic             w_shift;

`ifdef PARAM_SHIFT_REG_ROTATE_EN
  assign w_in_r = r_q[0];
  assign w_in_l = r_q[WIDTH-1];
`else
  assign w_in_r = sin_r;
  assign w_in_l = sin_l;
`endif

  assign w_shift = en && (mode == MODE_RIGHT || mode == MODE_LEFT);

  always_comb begin
    w_q_next    = r_q;
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  w_q_next = r_q;
        MODE_RIGHT: w_q_next = {w_in_r, r_q[WIDTH-1:1]};
        MODE_LEFT:  w_q_next = {r_q[WIDTH-2:0], w_in_l};
        MODE_LOAD: begin
          w_q_next   = pdin;
          w_cnt_next = '0;
        end
        default:    w_q_next = r_q;
      endcase
    end
    // Both shift directions advance one shared word counter.
    if (w_shift) begin
      if (r_cnt == LAST_CNT) begin
        w_cnt_next  = '0;
        w_done_next = 1'b1;
      end else begin
        w_cnt_next  = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= RST_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  assign q         = r_q;
  assign sout_r    = r_q[0];
  assign sout_l    = r_q[WIDTH-1];
  assign shift_cnt = r_cnt;
  assign word_done = r_done;

endmodule

// File: tb/tb_param_shift_reg.sv
// tb/tb_param_shift_reg.sv - directed table-driven bench for param_shift_reg (WIDTH=8).
module tb_param_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pdin;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [2:0] shift_cnt;
  logic       word_done;

  int checks   = 0;
  int failures = 0;

  param_shift_reg #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .pdin      (pdin),
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       sr;
    logic       sl;
    logic [7:0] pdin;
    logic [7:0] eq;
    logic [2:0] ec;
    logic       ed;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                     input logic [7:0] d, input logic [7:0] eq, input logic [2:0] ec,
                     input logic ed);
    vec_t v;
    v.en = e; v.mode = m; v.sr = sr; v.sl = sl; v.pdin = d;
    v.eq = eq; v.ec = ec; v.ed = ed;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input logic [2:0] ec,
                             input logic ed);
    check({tag, " q"}, 32'(q), 32'(eq));
    check({tag, " shift_cnt"}, 32'(shift_cnt), 32'(ec));
    check({tag, " word_done"}, 32'(word_done), 32'(ed));
    check({tag, " sout_r"}, 32'(sout_r), 32'(eq[0]));
    check({tag, " sout_l"}, 32'(sout_l), 32'(eq[7]));
  endtask

  always @(posedge clk) begin
    if (rst === 1'b1 && en === 1'b1 && $isunknown(mode)) begin
      failures++;
      $display("FAIL mode_x actual=%b expected=known", mode);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pdin = 8'h00;
    #3;
    check_state("reset_initial", 8'h00, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

`ifdef PARAM_SHIFT_REG_ROTATE_EN
    add(1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'hC0, 3'd1, 0);
    add(1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0);
    add(1, 2'b10, 1, 1, 8'h00, 8'h03, 3'd1, 0);
    add(1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'hC0, 3'd1, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'h60, 3'd2, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h30, 3'd3, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'h18, 3'd4, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h0C, 3'd5, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'h06, 3'd6, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h03, 3'd7, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h81, 3'd0, 1);
    add(1, 2'b00, 0, 0, 8'h00, 8'h81, 3'd0, 0);
`else
    // Load, then eight right shifts with sin_r=1.
    add(1, 2'b11, 0, 0, 8'hA5, 8'hA5, 3'd0, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hD2, 3'd1, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hE9, 3'd2, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hF4, 3'd3, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hFA, 3'd4, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hFD, 3'd5, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hFE, 3'd6, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hFF, 3'd7, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'hFF, 3'd0, 1);
    add(1, 2'b00, 1, 0, 8'h00, 8'hFF, 3'd0, 0);
    // Left shifts from 0x81 with an en-low gap after the third.
    add(1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h02, 3'd1, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h04, 3'd2, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h08, 3'd3, 0);
    add(0, 2'b10, 0, 1, 8'h00, 8'h08, 3'd3, 0);
    add(0, 2'b11, 1, 1, 8'hFF, 8'h08, 3'd3, 0);
    add(0, 2'b01, 1, 1, 8'h00, 8'h08, 3'd3, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h10, 3'd4, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h20, 3'd5, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h40, 3'd6, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h80, 3'd7, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h00, 3'd0, 1);
    // Load interrupts a partial word: no pulse.
    add(1, 2'b11, 0, 0, 8'h0F, 8'h0F, 3'd0, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h07, 3'd1, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h03, 3'd2, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h01, 3'd3, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h00, 3'd4, 0);
    add(1, 2'b11, 0, 0, 8'h3C, 8'h3C, 3'd0, 0);
    add(1, 2'b00, 0, 0, 8'h00, 8'h3C, 3'd0, 0);
    // Mixed directions share one counter.
    add(1, 2'b11, 0, 0, 8'h18, 8'h18, 3'd0, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h0C, 3'd1, 0);
    add(1, 2'b10, 0, 1, 8'h00, 8'h19, 3'd2, 0);
    add(1, 2'b01, 1, 0, 8'h00, 8'h8C, 3'd3, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h18, 3'd4, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h0C, 3'd5, 0);
    add(1, 2'b10, 0, 0, 8'h00, 8'h18, 3'd6, 0);
    add(1, 2'b01, 0, 0, 8'h00, 8'h0C, 3'd7, 0);
    add(1, 2'b10, 0, 1, 8'h00, 8'h19, 3'd0, 1);
    add(1, 2'b00, 0, 0, 8'h00, 8'h19, 3'd0, 0);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en; mode = vt[i].mode; sin_r = vt[i].sr; sin_l = vt[i].sl; pdin = vt[i].pdin;
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vt[i].eq, vt[i].ec, vt[i].ed);
    end

    // Asynchronous reset mid-word with q = 0x5A, shift_cnt = 1.
    en = 1'b1; mode = 2'b11; pdin = 8'hB4;
    @(posedge clk); #1;
    mode = 2'b01; sin_r = 1'b0;
    @(posedge clk); #1;
    check_state("pre_reset", 8'h5A, 3'd1, 1'b0);
    rst = 1'b0;
    #1;
    check_state("async_reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_state("reset_held", 8'h00, 3'd0, 1'b0);
    rst = 1'b1; mode = 2'b01; sin_r = 1'b1;
    @(posedge clk); #1;
    check_state("post_reset_shift", 8'h80, 3'd1, 1'b0);
    en = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
